// File: rtl/qsys_irq_ctrl.sv
// Avalon-MM interrupt controller: per-source edge/level capture, mask, priority
// report and a registered irq to the CPU, in the 16-bit / 3-bit-address slave format.
module qsys_irq_ctrl #(
  parameter int unsigned N_SRC       = 8,
  parameter int unsigned SYNC_STAGES = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             chipselect,
  input  logic [2:0]       address,
  input  logic             write_n,
  input  logic [15:0]      writedata,
  output logic [15:0]      readdata,
  input  logic [N_SRC-1:0] irq_src,
  output logic             irq
);

  localparam int unsigned DW = 16;
  localparam logic [DW-1:0] VMASK = DW'((32'(1) << N_SRC) - 32'(1));

  localparam logic [2:0] A_PENDING  = 3'd0;
  localparam logic [2:0] A_MASK     = 3'd1;
  localparam logic [2:0] A_EDGE_SEL = 3'd2;
  localparam logic [2:0] A_HIGHEST  = 3'd3;
  localparam logic [2:0] A_FORCE    = 3'd4;
  localparam logic [2:0] A_MISSED   = 3'd5;
  localparam logic [2:0] A_COUNT    = 3'd6;

  logic [N_SRC-1:0] s;
  logic [DW-1:0]    s16, prev, rise, cap;
  logic [DW-1:0]    pending, mask, edge_sel, missed, count;
  logic [DW-1:0]    pend_nxt, missed_nxt, count_nxt;
  logic [DW-1:0]    w1c_pend, w1c_missed, force_set;
  logic [DW-1:0]    pm, highest, rd_mux;
  logic             wr, any_cap;

  // Optional synchronizer on the raw sources
  if (SYNC_STAGES == 0) begin : g_nosync
    assign s = irq_src;
  end else begin : g_sync
    logic [N_SRC-1:0] sync_q [SYNC_STAGES];
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int k = 0; k < int'(SYNC_STAGES); k++) sync_q[k] <= '0;
      end else begin
        sync_q[0] <= irq_src;
        for (int k = 1; k < int'(SYNC_STAGES); k++) sync_q[k] <= sync_q[k-1];
      end
    end
    assign s = sync_q[SYNC_STAGES-1];
  end

  assign s16 = DW'(s);

  // Decode, capture and next-state logic
  always_comb begin
    wr         = chipselect && !write_n;
    w1c_pend   = (wr && address == A_PENDING) ? writedata : '0;
    w1c_missed = (wr && address == A_MISSED)  ? writedata : '0;
    force_set  = (wr && address == A_FORCE)   ? writedata : '0;
    rise       = s16 & ~prev;
    cap        = rise & edge_sel;
    any_cap    = |cap;

    // Edge bits: set outranks W1C; level bits simply follow the source.
    pend_nxt   = ((edge_sel & ((pending & ~w1c_pend) | rise | force_set)) |
                  (~edge_sel & s16)) & VMASK;
    missed_nxt = ((missed & ~w1c_missed) | (cap & pending)) & VMASK;

    count_nxt = count;
    if (wr && address == A_COUNT) begin
      count_nxt = any_cap ? DW'(1) : '0;
    end else if (any_cap && count != 16'hFFFF) begin
      count_nxt = count + DW'(1);
    end
  end

  // Lowest-index enabled pending source
  always_comb begin
    pm      = pending & mask;
    highest = '0;
    for (int i = DW - 1; i >= 0; i--) begin
      if (pm[i]) highest = {1'b1, 11'd0, 4'(i)};
    end
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      A_PENDING:  rd_mux = pending;
      A_MASK:     rd_mux = mask;
      A_EDGE_SEL: rd_mux = edge_sel;
      A_HIGHEST:  rd_mux = highest;
      A_MISSED:   rd_mux = missed;
      A_COUNT:    rd_mux = count;
      default:    rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev     <= '0;
      pending  <= '0;
      mask     <= '0;
      edge_sel <= VMASK;
      missed   <= '0;
      count    <= '0;
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      prev     <= s16;
      pending  <= pend_nxt;
      missed   <= missed_nxt;
      count    <= count_nxt;
      readdata <= rd_mux;
      irq      <= |pm;
      if (wr && address == A_MASK)     mask     <= writedata & VMASK;
      if (wr && address == A_EDGE_SEL) edge_sel <= writedata & VMASK;
    end
  end

endmodule
